lift_call_panel: RTL and testbench
==================================

# lift_call_panel

Floor-call front end for the `lift` controller. It latches hall and car button presses into a pending-call register, picks the next target floor with a SCAN (elevator) policy and drives the `floor` request into `lift`. It then watches the `lift_state` floor report to detect arrival, clears the served call and holds the doors open for a dwell period. It sits between the button/lamp panel and `lift`, and is the requester for that interface.

## Interface
- `DWELL_CYC`, default 4: door-open dwell length in cycles; legal range 1–255.
- `TIMEOUT_CYC`, default 64: arrival watchdog limit in cycles; used only with `LIFT_CALL_TIMEOUT_EN`; legal range 1–255.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn`  in  4  call buttons, one per floor 0–3, active-high; a level or a pulse of any length registers a call.
- `lift_state`  in  2  current car floor reported by `lift` (0–3).
- `floor`  out  2  target floor request to `lift`.
- `req_valid`  out  1  high while `floor` carries an active request (states SERVE and DWELL).
- `pending`  out  4  outstanding calls; also drives the button lamps.
- `dir`  out  1  travel direction: 1 = up, 0 = down.
- `door_open`  out  1  high in state DWELL.
- `fault`  out  1  sticky watchdog flag; constant 0 when the watchdog is compiled out.

## Operation
- Call latching: `pending[i]` is set on any cycle where `btn[i]` = 1. It is cleared only on service.
  - In DWELL, presses for the dwell floor are ignored.
  - If a press and a clear hit the same bit in the same cycle, the clear wins.
- State IDLE:
  - If `pending` = 0, stay in IDLE.
  - Otherwise select a target `T` using the SCAN rule below, register it on `floor`, and update `dir`:
    - `T` > `lift_state`: `dir` = 1.
    - `T` < `lift_state`: `dir` = 0.
    - `T` = `lift_state`: `dir` unchanged.
  - If `T` ≠ `lift_state`, go to SERVE.
  - If `T` = `lift_state`, clear `pending[T]` and go directly to DWELL.
- SCAN rule with `dir` = 1:
  - First choice: the lowest pending floor ≥ `lift_state`.
  - Otherwise: the highest pending floor < `lift_state`.
- SCAN rule with `dir` = 0:
  - First choice: the highest pending floor ≤ `lift_state`.
  - Otherwise: the lowest pending floor > `lift_state`.
- State SERVE:
  - `floor` is held constant; there is no retargeting.
  - When `lift_state` = `floor` is sampled, clear `pending[floor]`, load the dwell counter and go to DWELL.
- State DWELL:
  - The state lasts exactly `DWELL_CYC` cycles, with `door_open` = 1 and `req_valid` = 1.
  - On exit, go to IDLE; `req_valid` = 0 in IDLE.
- Counters are 8-bit, down-counting, and saturate at 0; they never wrap.
- Reset mid-operation: all state and outputs return to their reset values immediately (asynchronous), and the FSM returns to IDLE.

## Timing
- Reset values:
  - `floor` = 0, `req_valid` = 0, `pending` = 0, `dir` = 1, `door_open` = 0, `fault` = 0.
  - FSM in IDLE, both counters 0.
- Press-to-lamp latency: `btn` high before edge N gives `pending` set after edge N.
- Lamp-to-request latency: `pending` becomes visible after edge N; at edge N+1 `floor`/`req_valid` are valid and the FSM is in SERVE.
- Arrival latency: `lift_state` = `floor` sampled at edge M gives `pending` cleared and `door_open` = 1 after edge M.
- `door_open` falls after edge M + `DWELL_CYC`.
- The earliest next request is one cycle after that (one IDLE cycle minimum).
- Back-to-back same-floor service: at the selection edge, `pending` clears and `door_open` rises on the same edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `LIFT_CALL_TIMEOUT_EN`.
- Defined:
  - A watchdog counter loads `TIMEOUT_CYC` on entry to SERVE and decrements each SERVE cycle.
  - If it reaches 0 without arrival:
    - `fault` is set and stays set until `rst`.
    - The FSM returns to IDLE with `req_valid` = 0.
    - `pending[floor]` is kept, and normal SCAN reselection follows.
- Undefined:
  - There is no watchdog logic, and SERVE waits indefinitely.
  - `fault` is tied to 0.

## Test plan
- Reset, then hold: all outputs are at their reset values; with `btn` = 0, the FSM stays in IDLE and `req_valid` = 0 indefinitely.
- Single call: with the car model at 0, press `btn` = 0100 for 1 cycle.
  - `pending` = 0100, then `floor` = 2, `req_valid` = 1, `dir` = 1.
  - When the model reports `lift_state` = 2: `pending` = 0000 and `door_open` high for 4 cycles, then IDLE.
- SCAN order: car at 1, `dir` = 1, press floors 0 and 3 in the same cycle.
  - Floor 3 is served first (`dir` = 1), then floor 0 (`dir` = 0).
- Same-floor call: car at 2, press `btn` = 0100.
  - Goes directly to DWELL with no SERVE, `floor` = 2; `pending[2]` clears on the selection edge.
  - Re-pressing floor 2 during DWELL leaves `pending` = 0000.
- Reset mid-SERVE: assert `rst` while `floor` = 3 and `pending` = 1001.
  - Outputs go to reset values without waiting for a clock edge; after `rst` is released, the FSM is in IDLE with `pending` = 0.
- Watchdog (with `LIFT_CALL_TIMEOUT_EN`, `TIMEOUT_CYC` = 8): request floor 3 and hold `lift_state` = 0.
  - After 8 SERVE cycles: `fault` = 1, `req_valid` drops for one IDLE cycle, then floor 3 is requested again.
  - `fault` remains 1 until `rst`.

Source files
------------

// File: rtl/lift_call_panel.sv
// -----------------------------------------------------------------------------
// lift_call_panel
//
// Front end for floor calls to the lift controller. It latches button presses
// into a pending-call register. It uses a SCAN policy to pick the next target
// floor and issues a floor request to the lift. It then watches the reported
// car floor for arrival, clears the served call and holds the doors open for
// DWELL_CYC cycles.
//
// Parameters:
//   DWELL_CYC    door-open dwell length in cycles (1..255)
//   TIMEOUT_CYC  arrival watchdog limit in cycles (1..255); used only when
//                the optional watchdog is compiled in
//
// Optional feature macro:
//   LIFT_CALL_TIMEOUT_EN  enables the arrival watchdog and the sticky fault
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   btn[3:0]    call buttons, one per floor, active-high
//   lift_state  current car floor reported by the lift
//   floor       target floor request to the lift (registered)
//   req_valid   request active (SERVE and DWELL)
//   pending     outstanding calls, also drives the button lamps
//   dir         travel direction, 1 = up, 0 = down
//   door_open   high while dwelling at a floor
//   fault       sticky watchdog flag (0 when the watchdog is compiled out)
// -----------------------------------------------------------------------------
module lift_call_panel #(
  parameter int DWELL_CYC   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [1:0] lift_state,
  output logic [1:0] floor,
  output logic       req_valid,
  output logic [3:0] pending,
  output logic       dir,
  output logic       door_open,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t     state, state_d;
  logic [7:0] dwell_cnt;
  logic [1:0] target;
  logic       first_hit;
  logic       sel;
  logic       load_dwell;
  logic [3:0] clr_mask;
  logic [3:0] set_mask;
  logic       req_valid_d;
  logic       door_open_d;
  logic       timeout;

`ifdef LIFT_CALL_TIMEOUT_EN
  logic [7:0] wd_cnt;
`endif

  // ---------------------------------------------------------------------------
  // SCAN target selection. The loop order is chosen so that the last hit wins.
  // A descending walk therefore leaves the lowest match, and an ascending walk
  // leaves the highest.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    target    = lift_state;
    first_hit = 1'b0;
    if (dir) begin
      for (int i = 3; i >= 0; i--)
        if (pending[i] && i >= int'(lift_state)) begin
          target    = 2'(i);
          first_hit = 1'b1;
        end
      if (!first_hit)
        for (int i = 0; i < 4; i++)
          if (pending[i] && i < int'(lift_state)) target = 2'(i);
    end else begin
      for (int i = 0; i < 4; i++)
        if (pending[i] && i <= int'(lift_state)) begin
          target    = 2'(i);
          first_hit = 1'b1;
        end
      if (!first_hit)
        for (int i = 3; i >= 0; i--)
          if (pending[i] && i > int'(lift_state)) target = 2'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state;
    sel      = 1'b0;
    clr_mask = 4'b0000;
    timeout  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          sel = 1'b1;
          if (target == lift_state) begin
            clr_mask[target] = 1'b1;
            state_d          = DWELL;
          end else begin
            state_d = SERVE;
          end
        end
      end
      SERVE: begin
        if (lift_state == floor) begin
          clr_mask[floor] = 1'b1;
          state_d         = DWELL;
        end
`ifdef LIFT_CALL_TIMEOUT_EN
        // The counter is about to reach 0 without an arrival.
        else if (wd_cnt <= 8'd1) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      DWELL: begin
        if (dwell_cnt == 8'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_dwell = (state_d == DWELL) && (state != DWELL);
  // Presses for the floor being dwelt at are ignored. A clear beats a press.
  assign set_mask   = btn & ~((state == DWELL) ? (4'b0001 << floor) : 4'b0000);

  // ---------------------------------------------------------------------------
  // Output decode. The results are registered below, so no input reaches an
  // output combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_valid_d = (state_d != IDLE);
    door_open_d = (state_d == DWELL);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here is small control state, so all of it is reset.
    if (rst) begin
      pending   <= 4'b0000;
      floor     <= 2'd0;
      dir       <= 1'b1;
      dwell_cnt <= 8'd0;
      req_valid <= 1'b0;
      door_open <= 1'b0;
    end else begin
      pending   <= (pending | set_mask) & ~clr_mask;
      req_valid <= req_valid_d;
      door_open <= door_open_d;
      if (sel) begin
        floor <= target;
        if (target > lift_state)      dir <= 1'b1;
        else if (target < lift_state) dir <= 1'b0;
      end
      // DWELL lasts DWELL_CYC cycles. The exit is taken when the count is 0.
      if (load_dwell)
        dwell_cnt <= 8'(DWELL_CYC - 1);
      else if (state == DWELL && dwell_cnt != 8'd0)
        dwell_cnt <= dwell_cnt - 8'd1;
    end
  end

`ifdef LIFT_CALL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= 8'd0;
      fault  <= 1'b0;
    end else begin
      if (state_d == SERVE && state != SERVE)
        wd_cnt <= 8'(TIMEOUT_CYC);
      else if (state == SERVE && wd_cnt != 8'd0)
        wd_cnt <= wd_cnt - 8'd1;
      if (timeout) fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_lift_call_panel.sv
module tb_lift_call_panel;

  localparam int DWELL = 4;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [1:0] lift_state;
  logic [1:0] floor;
  logic       req_valid;
  logic [3:0] pending;
  logic       dir;
  logic       door_open;
  logic       fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] floor;
    logic       dir;
  } req_t;

  req_t sb[$];

  lift_call_panel #(.DWELL_CYC(DWELL), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .lift_state (lift_state),
    .floor      (floor),
    .req_valid  (req_valid),
    .pending    (pending),
    .dir        (dir),
    .door_open  (door_open),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] f, input logic d);
    req_t r;
    r.floor = f;
    r.dir   = d;
    sb.push_back(r);
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    step();
    btn = 4'b0000;
  endtask

  // Waits for the next request, then compares it with the scoreboard entry.
  // The car model then arrives, and the dwell length and idle gap are checked.
  task automatic serve_next();
    req_t exp;
    int   n;
    n = 0;
    while (!req_valid && n < 20) begin step(); n++; end
    checks++;
    if (!req_valid) begin
      errors++;
      $display("FAIL req_wait: req_valid=%0b required 1", req_valid);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: request floor=%0d with no expected entry", floor);
      return;
    end
    exp = sb.pop_front();
    if (floor !== exp.floor || dir !== exp.dir) begin
      errors++;
      $display("FAIL req_target: floor=%0d dir=%0b required floor=%0d dir=%0b",
               floor, dir, exp.floor, exp.dir);
    end
    if (!door_open) begin
      step();
      step();
      checks++;
      if (floor !== exp.floor || req_valid !== 1'b1 || door_open !== 1'b0) begin
        errors++;
        $display("FAIL serve_hold: floor=%0d req_valid=%0b door_open=%0b required %0d 1 0",
                 floor, req_valid, door_open, exp.floor);
      end
      lift_state = exp.floor;
      step();
      checks++;
      if (door_open !== 1'b1 || pending[exp.floor] !== 1'b0) begin
        errors++;
        $display("FAIL arrive: door_open=%0b pending=%b required door_open=1 bit %0d clear",
                 door_open, pending, exp.floor);
      end
    end
    n = 0;
    while (door_open && n < 300) begin step(); n++; end
    checks++;
    if (n != DWELL) begin
      errors++;
      $display("FAIL dwell_len: got %0d cycles required %0d", n, DWELL);
    end
    checks++;
    if (req_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_gap: req_valid=%0b required 0", req_valid);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    btn        = 4'b0000;
    lift_state = 2'd0;
    step();
    step();
    checks++;
    if (floor !== 2'd0 || req_valid !== 1'b0 || pending !== 4'b0000 ||
        dir !== 1'b1 || door_open !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: floor=%0d rv=%0b pend=%b dir=%0b door=%0b fault=%0b required 0 0 0000 1 0 0",
               floor, req_valid, pending, dir, door_open, fault);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (req_valid !== 1'b0 || pending !== 4'b0000 || door_open !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: cycle %0d rv=%0b pend=%b door=%0b required 0 0000 0",
                 i, req_valid, pending, door_open);
      end
    end
  endtask

  task automatic test_single();
    press(4'b0100);
    checks++;
    if (pending !== 4'b0100 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_lamp: pending=%b rv=%0b required 0100 0", pending, req_valid);
    end
    push(2'd2, 1'b1);
    serve_next();
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_clear: pending=%b required 0000", pending);
    end
  endtask

  task automatic test_same_floor();
    int n;
    // The car is at floor 2 with dir = 1.
    press(4'b0100);
    step();
    checks++;
    if (door_open !== 1'b1 || pending !== 4'b0000 || floor !== 2'd2 ||
        req_valid !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL same_direct: door=%0b pend=%b floor=%0d rv=%0b dir=%0b required 1 0000 2 1 1",
               door_open, pending, floor, req_valid, dir);
    end
    n = 1;
    press(4'b0100);
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("FAIL same_repress: pending=%b required 0000", pending);
    end
    if (door_open) n++;
    while (door_open && n < 300) begin
      step();
      if (door_open) n++;
    end
    checks++;
    if (n != DWELL) begin
      errors++;
      $display("FAIL same_dwell: got %0d cycles required %0d", n, DWELL);
    end
  endtask

  task automatic test_scan_up();
    lift_state = 2'd1;
    step();
    press(4'b1001);
    push(2'd3, 1'b1);
    push(2'd0, 1'b0);
    serve_next();
    serve_next();
  endtask

  task automatic test_scan_down();
    // The car is at 0 with dir = 0. It is moved to 2, and the direction is kept.
    lift_state = 2'd2;
    step();
    press(4'b1010);
    push(2'd1, 1'b0);
    push(2'd3, 1'b1);
    serve_next();
    serve_next();
    press(4'b0101);
    push(2'd2, 1'b0);
    push(2'd0, 1'b0);
    serve_next();
    serve_next();
  endtask

  task automatic test_back_to_back();
    // The car is at 0 with dir = 0. Floor 0 is served in place, then floor 1.
    press(4'b0011);
    push(2'd0, 1'b0);
    push(2'd1, 1'b1);
    serve_next();
    serve_next();
  endtask

  task automatic test_reset_mid();
    req_t exp;
    int   n;
    lift_state = 2'd1;
    step();
    press(4'b1000);
    push(2'd3, 1'b1);
    n = 0;
    while (!req_valid && n < 20) begin step(); n++; end
    exp = sb.pop_front();
    checks++;
    if (req_valid !== 1'b1 || floor !== exp.floor || dir !== exp.dir) begin
      errors++;
      $display("FAIL mid_req: rv=%0b floor=%0d dir=%0b required 1 %0d %0b",
               req_valid, floor, dir, exp.floor, exp.dir);
    end
    press(4'b0001);
    checks++;
    if (pending !== 4'b1001 || floor !== 2'd3) begin
      errors++;
      $display("FAIL mid_setup: pending=%b floor=%0d required 1001 3", pending, floor);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (floor !== 2'd0 || req_valid !== 1'b0 || pending !== 4'b0000 ||
        dir !== 1'b1 || door_open !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: floor=%0d rv=%0b pend=%b dir=%0b door=%0b fault=%0b required 0 0 0000 1 0 0",
               floor, req_valid, pending, dir, door_open, fault);
    end
    step();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (req_valid !== 1'b0 || pending !== 4'b0000 || door_open !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: rv=%0b pend=%b door=%0b required 0 0000 0",
               req_valid, pending, door_open);
    end
  endtask

`ifdef LIFT_CALL_TIMEOUT_EN
  task automatic test_watchdog();
    req_t exp;
    int   n;
    lift_state = 2'd0;
    step();
    press(4'b1000);
    push(2'd3, 1'b1);
    n = 0;
    while (!req_valid && n < 20) begin step(); n++; end
    exp = sb.pop_front();
    checks++;
    if (req_valid !== 1'b1 || floor !== exp.floor) begin
      errors++;
      $display("FAIL wd_req: rv=%0b floor=%0d required 1 %0d", req_valid, floor, exp.floor);
    end
    n = 1;
    while (req_valid && n < 300) begin
      step();
      if (req_valid) n++;
    end
    checks++;
    if (n != TMO || fault !== 1'b1 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL wd_trip: serve=%0d fault=%0b pend=%b required %0d 1 1000",
               n, fault, pending, TMO);
    end
    step();
    checks++;
    if (req_valid !== 1'b1 || floor !== 2'd3 || fault !== 1'b1) begin
      errors++;
      $display("FAIL wd_retry: rv=%0b floor=%0d fault=%0b required 1 3 1",
               req_valid, floor, fault);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL wd_clear: fault=%0b required 0", fault);
    end
    step();
    rst = 1'b0;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_same_floor();
    test_scan_up();
    test_scan_down();
    test_back_to_back();
    test_reset_mid();
`ifdef LIFT_CALL_TIMEOUT_EN
    test_watchdog();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries remain, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
